sequenced_weighted_mixer: RTL and testbench



---
 rtl/sequenced_weighted_mixer.sv | 105 ++++++++++
 tb/tb_sequenced_weighted_mixer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sequenced_weighted_mixer.sv
// Time-multiplexed N-input weighted mixer sharing one 16x17 multiplier and accumulator.
// Define MIXER_SATURATE_EN to clamp the mixed result instead of wrapping it to 16 bits.
module sequenced_weighted_mixer #(
   parameter int unsigned            N_INPUTS = 4,
   parameter logic [16*N_INPUTS-1:0] WEIGHTS  = {N_INPUTS{16'h2000}}
) (
   input  logic               clk,
   input  logic               I_RSTn,
   input  logic               audio_clk_en,
   input  logic signed [15:0] inputs [N_INPUTS],
   output logic signed [15:0] out,
   output logic               out_valid,
   output logic               busy,
   output logic               overrun
);

   localparam int unsigned IDXW = $clog2(N_INPUTS);
   localparam int unsigned ACCW = 33 + IDXW;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                 state;
   logic [IDXW-1:0]        idx;
   logic signed [ACCW-1:0] acc;
   logic signed [15:0]     snap [N_INPUTS];
   logic signed [32:0]     samp_ext;
   logic signed [32:0]     wght_ext;
   logic signed [32:0]     prod;
   logic signed [15:0]     result16;

   // Weights are unsigned Q1.15, so they enter the multiplier zero-extended.
   always_comb begin
      samp_ext = 33'(snap[idx]);
      wght_ext = {17'b0, WEIGHTS[16*idx +: 16]};
      prod     = samp_ext * wght_ext;
   end

`ifdef MIXER_SATURATE_EN
   localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
   localparam logic signed [ACCW-1:0] SAT_MIN = -ACCW'(32768);
   logic signed [ACCW-1:0] shifted;

   always_comb begin
      shifted = acc >>> 15;
      if (shifted > SAT_MAX)
         result16 = 16'sh7FFF;
      else if (shifted < SAT_MIN)
         result16 = 16'sh8000;
      else
         result16 = shifted[15:0];
   end
`else
   // Low 16 bits of the floored acc >>> 15.
   always_comb result16 = acc[30:15];
`endif

   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         state     <= IDLE;
         idx       <= '0;
         acc       <= '0;
         for (int unsigned i = 0; i < N_INPUTS; i++)
            snap[i] <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (audio_clk_en) begin
                  for (int unsigned i = 0; i < N_INPUTS; i++)
                     snap[i] <= inputs[i];
                  acc   <= '0;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc + ACCW'(prod);
               idx <= idx + IDXW'(1);
               if (idx == IDXW'(N_INPUTS - 1))
                  state <= DONE;
               if (audio_clk_en)
                  overrun <= 1'b1;
            end
            DONE: begin
               out       <= result16;
               out_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
               if (audio_clk_en)
                  overrun <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sequenced_weighted_mixer.sv
// Bench for sequenced_weighted_mixer: three N_INPUTS=2 instances with different weights
// driven in parallel and compared against an arithmetic reference model.
module tb_sequenced_weighted_mixer;

   localparam logic [31:0] W_A = {16'h4000, 16'h4000};
   localparam logic [31:0] W_B = {16'h0000, 16'h4000};
   localparam logic [31:0] W_C = {16'hFFFF, 16'hFFFF};

   logic               clk = 1'b0;
   logic               I_RSTn;
   logic               audio_clk_en;
   logic signed [15:0] din [2];
   logic signed [15:0] out_w  [3];
   logic               vld_w  [3];
   logic               busy_w [3];
   logic               ovr_w  [3];

   int                 n_tests = 0;
   int                 n_fail  = 0;
   logic               exp_ovr;
   logic [15:0]        exp_out [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sequenced_weighted_mixer #(
         .N_INPUTS(2),
         .WEIGHTS (g == 0 ? W_A : (g == 1 ? W_B : W_C))
      ) u_dut (
         .clk         (clk),
         .I_RSTn      (I_RSTn),
         .audio_clk_en(audio_clk_en),
         .inputs      (din),
         .out         (out_w[g]),
         .out_valid   (vld_w[g]),
         .busy        (busy_w[g]),
         .overrun     (ovr_w[g])
      );
   end

   function automatic logic [31:0] wsel(input int g);
      return (g == 0) ? W_A : ((g == 1) ? W_B : W_C);
   endfunction

   // Sum of sample*weight/32768 floored toward -inf, then wrapped or clamped.
   function automatic logic [15:0] model(input int g, input int a0, input int a1);
      logic [31:0] w;
      longint      s;
      longint      q;
      w = wsel(g);
      s = longint'(a0) * longint'(w[15:0]) + longint'(a1) * longint'(w[31:16]);
      q = s / 32768;
      if (s < 0 && (s % 32768) != 0)
         q = q - 1;
`ifdef MIXER_SATURATE_EN
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
`endif
      return q[15:0];
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic busy_e, input logic vld_e);
      for (int g = 0; g < 3; g++) begin
         check($sformatf("%s.busy[%0d]", tag, g), 16'(busy_w[g]), 16'(busy_e));
         check($sformatf("%s.valid[%0d]", tag, g), 16'(vld_w[g]), 16'(vld_e));
         check($sformatf("%s.out[%0d]", tag, g), out_w[g], exp_out[g]);
         check($sformatf("%s.ovr[%0d]", tag, g), 16'(ovr_w[g]), 16'(exp_ovr));
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Strobe at edge 0; result due after edge 3. Returns right after edge 3 so the
   // next call strobes at edge 4, the minimum legal spacing.
   task automatic run_sample(input string tag, input int a0, input int a1);
      din[0] = 16'(a0);
      din[1] = 16'(a1);
      audio_clk_en = 1'b1;
      tick;
      audio_clk_en = 1'b0;
      check_all({tag, ".e0"}, 1'b1, 1'b0);
      tick;
      check_all({tag, ".e1"}, 1'b1, 1'b0);
      tick;
      check_all({tag, ".e2"}, 1'b1, 1'b0);
      for (int g = 0; g < 3; g++)
         exp_out[g] = model(g, a0, a1);
      tick;
      check_all({tag, ".e3"}, 1'b0, 1'b1);
   endtask

   initial begin
      logic signed [15:0] r0;
      logic signed [15:0] r1;

      I_RSTn       = 1'b0;
      audio_clk_en = 1'b0;
      din[0]       = '0;
      din[1]       = '0;
      exp_ovr      = 1'b0;
      for (int g = 0; g < 3; g++)
         exp_out[g] = '0;

      #12;
      check_all("reset", 1'b0, 1'b0);
      #2 I_RSTn = 1'b1;
      tick;
      tick;
      check_all("idle", 1'b0, 1'b0);

      run_sample("basic", 3000, 1000);
      check("basic.const", out_w[0], 16'd2000);
      run_sample("floor", -1, 0);
      check("floor.const", out_w[1], 16'hFFFF);
      run_sample("ovfl", 32767, 32767);
`ifdef MIXER_SATURATE_EN
      check("ovfl.const", out_w[2], 16'h7FFF);
`else
      check("ovfl.const", out_w[2], 16'hFFFA);
`endif
      tick;
      check_all("gap", 1'b0, 1'b0);

      // Second strobe lands during MAC; the first snapshot must survive.
      din[0] = 16'sd100;
      din[1] = 16'sd300;
      audio_clk_en = 1'b1;
      tick;
      audio_clk_en = 1'b0;
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      din[0] = r0;
      din[1] = r1;
      tick;
      audio_clk_en = 1'b1;
      tick;
      audio_clk_en = 1'b0;
      exp_ovr = 1'b1;
      check_all("ovr.e2", 1'b1, 1'b0);
      for (int g = 0; g < 3; g++)
         exp_out[g] = model(g, 100, 300);
      tick;
      check_all("ovr.e3", 1'b0, 1'b1);
      tick;
      check_all("ovr.after", 1'b0, 1'b0);
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      run_sample("ovr.legal", int'(r0), int'(r1));

      // Reset between edges 1 and 2 of a sequence.
      tick;
      din[0] = 16'sd5000;
      din[1] = -16'sd7000;
      audio_clk_en = 1'b1;
      tick;
      audio_clk_en = 1'b0;
      tick;
      #2 I_RSTn = 1'b0;
      #1;
      exp_ovr = 1'b0;
      for (int g = 0; g < 3; g++)
         exp_out[g] = '0;
      check_all("rst.mid", 1'b0, 1'b0);
      #2 I_RSTn = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick;
         check_all($sformatf("rst.quiet%0d", c), 1'b0, 1'b0);
      end
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      run_sample("rst.next", int'(r0), int'(r1));

      for (int k = 0; k < 20; k++) begin
         r0 = 16'($urandom);
         r1 = 16'($urandom);
         run_sample($sformatf("b2b%0d", k), int'(r0), int'(r1));
      end
      tick;
      check_all("end", 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
